// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed circular fetch queue between the front end and the BE scheduler.
// Entries remain resident after issue until committed (deq), flushed (clr) or replayed (roll).
module bp_be_fe_queue_ckpt #(
    parameter int els_p   = 8,
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,

    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,

    input  logic               fe_queue_clr_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_deq_i,
    output logic               fe_queue_empty_o
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, wptr_d;
    logic [ptr_w-1:0]   rptr_q, rptr_d;
    logic [ptr_w-1:0]   cptr_q, cptr_d;
    logic [ptr_w-1:0]   cptr_inc;

    logic full;
    logic enq;
    logic yumi_ok;
    logic deq_ok;

    // Full when the index bits match but the wrap bits differ.
    assign full = (wptr_q[idx_w-1:0] == cptr_q[idx_w-1:0]) &&
                  (wptr_q[idx_w] != cptr_q[idx_w]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = (rptr_q != wptr_q);
    assign fe_queue_empty_o = (wptr_q == cptr_q);
    assign fe_queue_o       = mem_q[rptr_q[idx_w-1:0]];

    assign enq     = fe_queue_v_i & ~full & ~fe_queue_clr_i & ~reset_i;
    assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o;
    assign deq_ok  = fe_queue_deq_i & (cptr_q != rptr_q);

    assign cptr_inc = cptr_q + ptr_w'(deq_ok);

    always_comb begin
        wptr_d = wptr_q + ptr_w'(enq);
        rptr_d = rptr_q + ptr_w'(yumi_ok);
        cptr_d = cptr_inc;
        if (fe_queue_clr_i) begin
            rptr_d = wptr_q;
            cptr_d = wptr_q;
        end else if (fe_queue_roll_i) begin
            // Replay restarts from the commit point including this cycle's retire.
            rptr_d = cptr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[idx_w-1:0]] <= fe_queue_i;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Bench for bp_be_fe_queue_ckpt: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_bp_be_fe_queue_ckpt;

    localparam int EL = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         fe_queue_clr_i;
    logic         fe_queue_roll_i;
    logic         fe_queue_deq_i;
    logic         fe_queue_empty_o;

    always #5 clk = ~clk;

    bp_be_fe_queue_ckpt #(.els_p(EL), .width_p(W)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .fe_queue_clr_i   (fe_queue_clr_i),
        .fe_queue_roll_i  (fe_queue_roll_i),
        .fe_queue_deq_i   (fe_queue_deq_i),
        .fe_queue_empty_o (fe_queue_empty_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference: every resident entry in age order, plus how many of them were read.
    logic [W-1:0] mq[$];
    int           rd = 0;
    int           ill_yumi_model = 0;
    int           ill_yumi_seen  = 0;
    int           ill_deq_model  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outs();
        check_val("v_o",     32'(fe_queue_v_o),     32'(rd < mq.size()));
        check_val("ready_o", 32'(fe_queue_ready_o), 32'(mq.size() < EL));
        check_val("empty_o", 32'(fe_queue_empty_o), 32'(mq.size() == 0));
        if (rd < mq.size()) check_val("data", 32'(fe_queue_o), 32'(mq[rd]));
    endtask

    task automatic model_update(input bit v, input logic [W-1:0] d, input bit y,
                                input bit dq, input bit rl, input bit cl, input bit rs);
        bit enq_ok, dq_ok, y_ok;
        if (rs || cl) begin
            mq.delete();
            rd = 0;
        end else begin
            enq_ok = v && (mq.size() < EL);
            dq_ok  = dq && (rd > 0);
            y_ok   = y && (rd < mq.size());
            if (rl) begin
                if (dq_ok) void'(mq.pop_front());
                rd = 0;
            end else begin
                if (dq_ok) begin
                    void'(mq.pop_front());
                    rd--;
                end
                if (y_ok) rd++;
            end
            if (enq_ok) mq.push_back(d);
        end
    endtask

    // One clock: check state-derived outputs, watch for illegal ops, advance DUT and model.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit y,
                         input bit dq, input bit rl, input bit cl, input bit rs);
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = y;
        fe_queue_deq_i  = dq;
        fe_queue_roll_i = rl;
        fe_queue_clr_i  = cl;
        reset_i         = rs;
        check_outs();
        if (y && !fe_queue_v_o) ill_yumi_seen++;
        if (y && !(rd < mq.size())) ill_yumi_model++;
        if (dq && !rl && !cl && !rs && rd == 0) ill_deq_model++;
        @(posedge clk);
        model_update(v, d, y, dq, rl, cl, rs);
        #1;
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq(input logic [W-1:0] d);
        drive(1, d, 0, 0, 0, 0, 0);
    endtask

    task automatic yumi();
        drive(0, '0, 1, 0, 0, 0, 0);
    endtask

    task automatic flush();
        drive(0, '0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        fe_queue_i = '0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
        fe_queue_clr_i = 0; fe_queue_roll_i = 0; fe_queue_deq_i = 0;
        reset_i = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 0;
        check_val("rst_v",     32'(fe_queue_v_o),     32'd0);
        check_val("rst_ready", 32'(fe_queue_ready_o), 32'd1);
        check_val("rst_empty", 32'(fe_queue_empty_o), 32'd1);

        // Basic flow
        enq(8'h11);
        check_val("basic_v_next", 32'(fe_queue_v_o), 32'd1);
        check_val("basic_first",  32'(fe_queue_o),   32'h11);
        enq(8'h22);
        enq(8'h33);
        yumi();
        check_val("basic_second", 32'(fe_queue_o), 32'h22);
        yumi();
        check_val("basic_third",  32'(fe_queue_o), 32'h33);
        yumi();
        drive(0, '0, 0, 1, 0, 0, 0);
        drive(0, '0, 0, 1, 0, 0, 0);
        check_val("basic_not_empty", 32'(fe_queue_empty_o), 32'd0);
        drive(0, '0, 0, 1, 0, 0, 0);
        check_val("basic_empty", 32'(fe_queue_empty_o), 32'd1);

        // Full / backpressure
        enq(8'h11); enq(8'h22); enq(8'h33); enq(8'h44);
        check_val("full_ready0", 32'(fe_queue_ready_o), 32'd0);
        yumi();
        drive(1, 8'h55, 0, 1, 0, 0, 0);
        check_val("full_ready1", 32'(fe_queue_ready_o), 32'd1);
        check_val("full_55_refused", 32'(mq.size()), 32'd3);
        enq(8'h55);
        yumi(); yumi();
        check_val("full_44", 32'(fe_queue_o), 32'h44);
        yumi();
        check_val("full_55", 32'(fe_queue_o), 32'h55);
        flush();

        // Roll replay
        enq(8'hA0); enq(8'hA1); enq(8'hA2); enq(8'hA3);
        yumi(); yumi(); yumi();
        drive(0, '0, 0, 1, 0, 0, 0);
        drive(0, '0, 0, 0, 1, 0, 0);
        check_val("roll_v",  32'(fe_queue_v_o), 32'd1);
        check_val("roll_a1", 32'(fe_queue_o),   32'hA1);
        yumi();
        check_val("roll_a2", 32'(fe_queue_o),   32'hA2);
        yumi();
        check_val("roll_a3", 32'(fe_queue_o),   32'hA3);
        flush();

        // Roll together with deq
        enq(8'hA0); enq(8'hA1); enq(8'hA2); enq(8'hA3);
        yumi(); yumi();
        drive(0, '0, 1, 1, 1, 0, 0);
        check_val("rolldeq_a1",    32'(fe_queue_o),       32'hA1);
        check_val("rolldeq_ready", 32'(fe_queue_ready_o), 32'd1);
        flush();

        // Clr drops a same-cycle enqueue
        enq(8'h01); enq(8'h02); enq(8'h03);
        drive(1, 8'h77, 1, 1, 1, 1, 0);
        check_val("clr_v",     32'(fe_queue_v_o),     32'd0);
        check_val("clr_empty", 32'(fe_queue_empty_o), 32'd1);
        check_val("clr_ready", 32'(fe_queue_ready_o), 32'd1);
        idle(); idle();

        // Wrap-around streaming with read-and-commit every cycle
        for (int i = 0; i < 10; i++)
            drive(1, 8'(i), rd < mq.size(), rd > 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, '0, rd < mq.size(), rd > 0, 0, 0, 0);
        check_val("wrap_drained", 32'(fe_queue_empty_o), 32'd1);
        yumi();
        check_val("ill_yumi_v", 32'(fe_queue_v_o), 32'd0);
        enq(8'h5A);
        drive(0, '0, 0, 1, 0, 0, 0);
        check_val("ill_deq_held", 32'(fe_queue_o), 32'h5A);
        yumi();
        drive(0, '0, 0, 1, 0, 0, 0);
        check_val("ill_deq_then_empty", 32'(fe_queue_empty_o), 32'd1);

        // Reset mid-operation
        enq(8'hC1); enq(8'hC2);
        drive(0, '0, 0, 0, 0, 0, 1);
        check_val("mrst_v",     32'(fe_queue_v_o),     32'd0);
        check_val("mrst_ready", 32'(fe_queue_ready_o), 32'd1);
        check_val("mrst_empty", 32'(fe_queue_empty_o), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 6,
                  8'($urandom),
                  ($urandom_range(0, 9) < 5) && (rd < mq.size() || $urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 4) && (rd > 0 || $urandom_range(0, 19) == 0),
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) == 0);
        end
        idle();

        check_val("ill_yumi_count", 32'(ill_yumi_seen), 32'(ill_yumi_model));
        check_val("ill_deq_injected", 32'(ill_deq_model > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
